// File: rtl/bft_host_endpoint.sv
// Host-side BFT leaf endpoint: packs a 32-bit user stream into credited BFT packets and
// unpacks inbound packets into a FIFO-backed stream. Define BFT_HOST_SEQ_CHECK_EN for seq_err.
module bft_host_endpoint #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 4,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 8,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int RX_FIFO_DEPTH         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
  input  logic [PAYLOAD_BITS-1:0]  s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  output logic [PAYLOAD_BITS-1:0]  m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [NUM_ADDR_BITS:0]   credit_count,
  output logic                     rx_overflow
`ifdef BFT_HOST_SEQ_CHECK_EN
  ,
  output logic                     seq_err
`endif
);

  localparam int CW       = NUM_ADDR_BITS + 1;
  localparam int PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;
  localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;
  localparam int VALID    = PACKET_BITS - 1;
  localparam int FIFO_AW  = $clog2(RX_FIFO_DEPTH);
  localparam int CONS_W   = $clog2(FREESPACE_UPDATE_SIZE + 1);
  localparam int PEND_W   = 4;

  localparam logic [CW-1:0]           CREDIT_FULL = CW'(2 ** NUM_ADDR_BITS);
  localparam logic [CW:0]             SUM_MAX     = (CW + 1)'(2 ** NUM_ADDR_BITS);
  localparam logic [CW:0]             SUM_ONE     = 1;
  localparam logic [NUM_ADDR_BITS-1:0] SEQ_ONE    = 1;
  localparam logic [FIFO_AW:0]        PTR_ONE     = 1;
  localparam logic [CONS_W-1:0]       CONS_ONE    = 1;
  localparam logic [CONS_W-1:0]       CONS_LAST   = CONS_W'(FREESPACE_UPDATE_SIZE - 1);
  localparam logic [PEND_W-1:0]       PEND_ONE    = 1;
  localparam logic [PAYLOAD_BITS-1:0] UPDATE_WORD = PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE);

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_CREDIT, SLOT_DATA} slot_e;

  slot_e                     slot;
  logic [NUM_ADDR_BITS-1:0]  tx_seq;
  logic [PEND_W-1:0]         pending, pending_next;
  logic [CONS_W-1:0]         consumed;
  logic [CW:0]               credit_sum;
  logic [CW-1:0]             credit_next;
  logic [PAYLOAD_BITS-1:0]   mem [RX_FIFO_DEPTH];
  logic [FIFO_AW:0]          wr_ptr, rd_ptr;
  logic                      fifo_empty, fifo_full, push, pop, cons_hit;
  logic                      din_valid, din_is_credit, din_is_data;
  logic [NUM_PORT_BITS-1:0]  din_port;
  logic [NUM_ADDR_BITS-1:0]  din_seq;

  assign din_valid     = din_leaf_bft2interface[VALID];
  assign din_port      = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
  assign din_seq       = din_leaf_bft2interface[PAYLOAD_BITS +: NUM_ADDR_BITS];
  assign din_is_credit = din_valid && (din_port == '0);
  assign din_is_data   = din_valid && (din_port != '0);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign m_tvalid   = !fifo_empty;
  assign m_tdata    = mem[rd_ptr[FIFO_AW-1:0]];
  assign pop        = m_tvalid && m_tready;
  // A pop frees the slot this cycle, so a push on a full FIFO is still accepted.
  assign push       = din_is_data && (!fifo_full || pop);
  assign cons_hit   = pop && (consumed == CONS_LAST);

  assign s_tready = !reset && (credit_count != '0) && (pending == '0);

  always_comb begin
    slot = SLOT_IDLE;
    if (pending != '0)
      slot = SLOT_CREDIT;
    else if (s_tvalid && (credit_count != '0))
      slot = SLOT_DATA;
  end

  // Widened sum keeps decrement and credit return exact before saturating.
  always_comb begin
    credit_sum = {1'b0, credit_count};
    if (din_is_credit)
      credit_sum = credit_sum + {1'b0, din_leaf_bft2interface[CW-1:0]};
    if (slot == SLOT_DATA)
      credit_sum = credit_sum - SUM_ONE;
    credit_next = (credit_sum > SUM_MAX) ? CREDIT_FULL : credit_sum[CW-1:0];
  end

  always_comb begin
    pending_next = pending;
    if (cons_hit && (slot != SLOT_CREDIT) && (pending != '1))
      pending_next = pending + PEND_ONE;
    else if (!cons_hit && (slot == SLOT_CREDIT))
      pending_next = pending - PEND_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_leaf_interface2bft <= '0;
      credit_count            <= CREDIT_FULL;
      tx_seq                  <= '0;
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      rx_overflow             <= 1'b0;
      pending                 <= '0;
      consumed                <= '0;
    end else begin
      case (slot)
        SLOT_CREDIT: dout_leaf_interface2bft <= {1'b1, cfg_dest_leaf, {NUM_PORT_BITS{1'b0}},
                                                 {NUM_ADDR_BITS{1'b0}}, UPDATE_WORD};
        SLOT_DATA:   dout_leaf_interface2bft <= {1'b1, cfg_dest_leaf, cfg_dest_port,
                                                 tx_seq, s_tdata};
        default:     dout_leaf_interface2bft <= '0;
      endcase
      credit_count <= credit_next;
      pending      <= pending_next;
      if (slot == SLOT_DATA)
        tx_seq <= tx_seq + SEQ_ONE;
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        consumed <= cons_hit ? '0 : consumed + CONS_ONE;
      end
      if (din_is_data && !push)
        rx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[FIFO_AW-1:0]] <= din_leaf_bft2interface[PAYLOAD_BITS-1:0];
  end

`ifdef BFT_HOST_SEQ_CHECK_EN
  logic [NUM_ADDR_BITS-1:0] rx_seq;
  logic                     unused_din;

  assign unused_din = ^din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS];

  // Expected seq resyncs on every data packet, including ones dropped on a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_seq  <= '0;
      seq_err <= 1'b0;
    end else if (din_is_data) begin
      if (din_seq != rx_seq)
        seq_err <= 1'b1;
      rx_seq <= din_seq + SEQ_ONE;
    end
  end
`else
  logic unused_din;

  assign unused_din = ^{din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS], din_seq};
`endif

endmodule
